mpsoc_wb_spram_arbiter: RTL and testbench

//  Round-robin arbiter sharing one mpsoc_wb_spram Wishbone slave port between NM masters.

---
 rtl/mpsoc_wb_spram_arbiter.sv | 148 ++++++++++++++
 tb/tb_mpsoc_wb_spram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_wb_spram_arbiter.sv
// rtl/mpsoc_wb_spram_arbiter.sv - round-robin Wishbone arbiter in front of one mpsoc_wb_spram port
// Optional stall timeout with forced error: define MPSOC_WB_SPRAM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mpsoc_wb_spram_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*2-1:0]  m_bte_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    grant_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic [1:0]       s_bte_o,
  output logic [2:0]       s_cti_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic [DW-1:0]    s_dat_i
);
  localparam int IW = $clog2(NM);

`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt, last, last_nxt, pick;
  logic [NM-1:0]   grant, grant_nxt, req;
  logic            cyc_g, stb_g, hit, found;
  int              idx;

  assign req   = m_cyc_i & m_stb_i;
  assign cyc_g = m_cyc_i[owner];
  assign stb_g = m_stb_i[owner];

`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       stalled;
  assign stalled = (state == GRANT) & cyc_g & stb_g & ~s_ack_i & ~s_err_i;
  assign hit     = stalled & (tcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETn)             tcnt <= '0;
    else if (stalled && !hit) tcnt <= tcnt + 8'd1;
    else                      tcnt <= '0;
  end
`else
  assign hit = 1'b0;
`endif

  // Search starts just after the last owner so every requester is reached within NM grants.
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = 0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(last) + k) % NM;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          grant_nxt = NM'(1) << pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (hit) begin
`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
          state_nxt = ERR;
`endif
        end else if (!cyc_g) begin
          last_nxt  = owner;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
      ERR: begin
        if (!cyc_g) begin
          last_nxt  = owner;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NM - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      grant <= grant_nxt;
    end
  end

  // The bus is only driven in GRANT, so stray slave responses while idle never reach a master.
  assign s_cyc_o = (state == GRANT) & cyc_g & ~hit;
  assign s_stb_o = (state == GRANT) & stb_g & ~hit;
  assign s_adr_o = m_adr_i[owner*AW +: AW];
  assign s_dat_o = m_dat_i[owner*DW +: DW];
  assign s_sel_o = m_sel_i[owner*4 +: 4];
  assign s_we_o  = m_we_i[owner];
  assign s_bte_o = m_bte_i[owner*2 +: 2];
  assign s_cti_o = m_cti_i[owner*3 +: 3];

  assign m_ack_o = (s_ack_i & s_cyc_o) ? grant : '0;
  assign m_err_o = ((s_err_i & s_cyc_o) | hit) ? grant : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant;
endmodule

// File: tb/tb_mpsoc_wb_spram_arbiter.sv
// tb/tb_mpsoc_wb_spram_arbiter.sv - directed bench with a cycle model for mpsoc_wb_spram_arbiter
`timescale 1ns/1ps
module tb_mpsoc_wb_spram_arbiter;
  localparam int NM = 2, AW = 8, DW = 32;
`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic HCLK = 1'b0, HRESETn;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, grant_o;
  logic [NM*2-1:0]  m_bte_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
  logic [AW-1:0]    s_adr_o;
  logic [3:0]       s_sel_o;
  logic [1:0]       s_bte_o;
  logic [2:0]       s_cti_o;
  logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;

  always #5 HCLK = ~HCLK;

  mpsoc_wb_spram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_bte_i(m_bte_i), .m_cti_i(m_cti_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o), .grant_o(grant_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i)
  );

  int vectors = 0, miscompares = 0, cyc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge HCLK) cyc_n <= cyc_n + 1;

  // RAM: one ack per beat after a wait cycle; unwritten words read back as C0FFEE_<adr>.
  logic [DW-1:0] mem [0:255];
  bit [255:0]    wrv;
  logic          ack_q, ram_stall, spur;
  assign s_ack_i = ack_q | spur;
  assign s_err_i = spur;
  always_comb s_dat_i = wrv[s_adr_o] ? mem[s_adr_o] : {24'hC0FFEE, s_adr_o};
  always @(posedge HCLK) begin
    if (!HRESETn) ack_q <= 1'b0;
    else begin
      ack_q <= s_cyc_o & s_stb_o & ~ack_q & ~ram_stall;
      if (ack_q & s_cyc_o & s_stb_o & s_we_o) begin
        mem[s_adr_o] <= s_dat_o;
        wrv[s_adr_o] <= 1'b1;
      end
    end
  end

  typedef struct { bit we; logic [AW-1:0] adr; logic [DW-1:0] dat; int beats; bit gap; } tx_t;
  tx_t          txq [NM][$];
  logic [DW-1:0] rdq [NM][$];
  bit           active [NM], hold [NM];
  int           beat [NM], acks [NM], errs [NM], start_cyc [NM];

  task automatic drive_beat(input int i);
    tx_t t;
    t = txq[i][0];
    m_cyc_i[i] = 1'b1;
    m_stb_i[i] = 1'b1;
    m_we_i[i]  = t.we;
    m_adr_i[i*AW +: AW] = t.adr + AW'(beat[i]);
    m_dat_i[i*DW +: DW] = t.dat + DW'(beat[i]);
    m_sel_i[i*4 +: 4] = 4'hf;
    m_bte_i[i*2 +: 2] = 2'b00;
    m_cti_i[i*3 +: 3] = (t.beats == 1) ? 3'b000 : (beat[i] == t.beats - 1) ? 3'b111 : 3'b010;
  endtask

  task automatic step(input int i, input logic ack, input logic err, input logic [DW-1:0] dat);
    if (active[i]) begin
      if (hold[i]) begin
        hold[i] = 1'b0;
        drive_beat(i);
      end else if (ack || err) begin
        if (ack) acks[i]++;
        if (err) errs[i]++;
        if (ack && !txq[i][0].we) rdq[i].push_back(dat);
        beat[i]++;
        if (err || beat[i] == txq[i][0].beats) begin
          active[i] = 1'b0;
          void'(txq[i].pop_front());
          m_cyc_i[i] = 1'b0;
          m_stb_i[i] = 1'b0;
        end else if (txq[i][0].gap) begin
          hold[i] = 1'b1;
          m_stb_i[i] = 1'b0;
        end else drive_beat(i);
      end
    end else if (txq[i].size() != 0) begin
      active[i] = 1'b1;
      beat[i] = 0;
      start_cyc[i] = cyc_n;
      drive_beat(i);
    end
  endtask

  // Master engine: responds to the acks seen in the previous cycle.
  initial begin : engine
    logic [NM-1:0] ack_n, err_n;
    logic [DW-1:0] dat_n;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_bte_i = '0; m_cti_i = '0; m_cyc_i = '0; m_stb_i = '0;
    for (int i = 0; i < NM; i++) begin
      active[i] = 0; hold[i] = 0; beat[i] = 0; acks[i] = 0; errs[i] = 0; start_cyc[i] = 0;
    end
    forever begin
      @(negedge HCLK);
      ack_n = m_ack_o; err_n = m_err_o; dat_n = m_dat_o;
      @(posedge HCLK);
      #2;
      for (int i = 0; i < NM; i++) step(i, ack_n[i], err_n[i], dat_n);
    end
  end

  // Reference model: owner index (-1 idle) plus round-robin pointer, advanced once per edge.
  int            glog_idx [$], glog_cyc [$];
  initial begin : model
    int owner, mlast, tcnt, c;
    bit in_err, hit, stall, e_cyc, e_stb, s_rstn, s_hit, s_stall;
    logic [NM-1:0] e_grant, e_ack, e_err, s_req, s_mcyc, prev_g;
    owner = -1; mlast = NM - 1; tcnt = 0; in_err = 0;
    s_rstn = 0; s_hit = 0; s_stall = 0; s_req = '0; s_mcyc = '0; prev_g = '0;
    forever begin
      @(posedge HCLK);
      if (!s_rstn) begin
        owner = -1; mlast = NM - 1; in_err = 0; tcnt = 0;
      end else if (owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          c = (mlast + k) % NM;
          if (owner < 0 && s_req[c]) owner = c;
        end
      end else if (in_err) begin
        if (!s_mcyc[owner]) begin mlast = owner; owner = -1; in_err = 0; end
      end else if (s_hit) begin
        in_err = 1; tcnt = 0;
      end else if (!s_mcyc[owner]) begin
        mlast = owner; owner = -1; tcnt = 0;
      end else tcnt = s_stall ? tcnt + 1 : 0;

      @(negedge HCLK);
      e_grant = (owner >= 0) ? NM'(1) << owner : '0;
      hit = 0; stall = 0; e_cyc = 0; e_stb = 0;
      if (owner >= 0 && !in_err) begin
        stall = m_cyc_i[owner] && m_stb_i[owner] && !s_ack_i && !s_err_i;
        hit = TMO_EN && stall && (tcnt == TMO - 1);
        e_cyc = m_cyc_i[owner] && !hit;
        e_stb = m_stb_i[owner] && !hit;
      end
      e_ack = (s_ack_i && e_cyc) ? e_grant : '0;
      e_err = ((s_err_i && e_cyc) || hit) ? e_grant : '0;
      chk("grant_o", 64'(grant_o), 64'(e_grant));
      chk("s_cyc_o", 64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb_o", 64'(s_stb_o), 64'(e_stb));
      chk("m_ack_o", 64'(m_ack_o), 64'(e_ack));
      chk("m_err_o", 64'(m_err_o), 64'(e_err));
      if (e_cyc) begin
        chk("s_adr_o", 64'(s_adr_o), 64'(m_adr_i[owner*AW +: AW]));
        chk("s_we_o", 64'(s_we_o), 64'(m_we_i[owner]));
        chk("s_sel_o", 64'(s_sel_o), 64'(m_sel_i[owner*4 +: 4]));
        chk("s_cti_o", 64'(s_cti_o), 64'(m_cti_i[owner*3 +: 3]));
        chk("s_bte_o", 64'(s_bte_o), 64'(m_bte_i[owner*2 +: 2]));
        if (m_we_i[owner]) chk("s_dat_o", 64'(s_dat_o), 64'(m_dat_i[owner*DW +: DW]));
      end
      if (grant_o != '0 && prev_g == '0) begin
        glog_idx.push_back(grant_o[1] ? 1 : 0);
        glog_cyc.push_back(cyc_n);
      end
      prev_g = grant_o;
      s_rstn = HRESETn; s_req = m_cyc_i & m_stb_i; s_mcyc = m_cyc_i;
      s_hit = hit; s_stall = stall;
    end
  end

  function automatic tx_t mk(bit we, logic [AW-1:0] adr, logic [DW-1:0] dat, int beats, bit gap);
    tx_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.beats = beats; t.gap = gap;
    return t;
  endfunction

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge HCLK); #3;
      done = 1;
      for (int i = 0; i < NM; i++) if (active[i] || txq[i].size() != 0) done = 0;
      if (grant_o != '0) done = 0;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL %s: bus still busy after 400 cycles", name);
    end
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  task automatic clear_logs();
    glog_idx.delete(); glog_cyc.delete();
    for (int i = 0; i < NM; i++) rdq[i].delete();
  endtask

  initial begin : main
    int a0, a1;
    bit seen;
    HRESETn = 1'b0; spur = 1'b0; ram_stall = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("reset grant_o", 64'(grant_o), 64'd0);
    chk("reset s_cyc_o", 64'(s_cyc_o), 64'd0);
    @(posedge HCLK); #1;

    // Simultaneous first requests: m0 first, one cycle latency, one idle cycle, then m1.
    clear_logs();
    txq[0].push_back(mk(1, 8'h00, 32'h1111_0000, 1, 0));
    txq[1].push_back(mk(1, 8'h01, 32'h2222_0000, 1, 0));
    wait_idle("t1");
    chk("t1 grants", 64'(glog_idx.size()), 64'd2);
    chk("t1 first", 64'(glog_idx[0]), 64'd0);
    chk("t1 second", 64'(glog_idx[1]), 64'd1);
    chk("t1 latency", 64'(glog_cyc[0] - start_cyc[0]), 64'd1);
    chk("t1 regrant gap", 64'(glog_cyc[1] - glog_cyc[0]), 64'd4);

    // Back-to-back contention: strict alternation.
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      txq[0].push_back(mk(1, 8'h50 + 8'(k), 32'h5000 + k, 1, 0));
      txq[1].push_back(mk(1, 8'h60 + 8'(k), 32'h6000 + k, 1, 0));
    end
    wait_idle("t4");
    chk("t4 grants", 64'(glog_idx.size()), 64'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("t4 grant%0d", k), 64'(glog_idx[k]), 64'(k % 2));

    // m0 writes, m1 reads back through the same RAM.
    clear_logs();
    txq[0].push_back(mk(1, 8'h10, 32'hDEAD_BEEF, 1, 0));
    wait_idle("t2w");
    a0 = acks[0];
    txq[1].push_back(mk(0, 8'h10, 32'h0, 1, 0));
    wait_idle("t2r");
    chk("t2 read data", 64'(rdq[1][0]), 64'hDEAD_BEEF);
    chk("t2 m0 acks", 64'(acks[0] - a0), 64'd0);

    // m1 burst with stb gaps holds the bus against a waiting m0.
    clear_logs();
    a1 = acks[1];
    txq[1].push_back(mk(0, 8'h20, 32'h0, 4, 1));
    repeat (2) @(posedge HCLK); #1;
    txq[0].push_back(mk(0, 8'h30, 32'h0, 1, 0));
    wait_idle("t3");
    chk("t3 grants", 64'(glog_idx.size()), 64'd2);
    chk("t3 first", 64'(glog_idx[0]), 64'd1);
    chk("t3 second", 64'(glog_idx[1]), 64'd0);
    chk("t3 m1 acks", 64'(acks[1] - a1), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("t3 beat%0d", k), 64'(rdq[1][k]), 64'(32'hC0FFEE20 + k));
    chk("t3 m0 data", 64'(rdq[0][0]), 64'hC0FFEE30);

    // Slave responses while idle are never forwarded.
    spur = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      chk("idle ack", 64'({m_ack_o, m_err_o}), 64'd0);
    end
    @(posedge HCLK); #1 spur = 1'b0;

    // Reset in the middle of an m0 burst.
    clear_logs();
    a0 = acks[0];
    txq[0].push_back(mk(0, 8'h40, 32'h0, 4, 0));
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(posedge HCLK); #3;
      if (acks[0] > a0) seen = 1;
    end
    chk("t5 burst started", 64'(seen), 64'd1);
    txq[1].push_back(mk(0, 8'h41, 32'h0, 1, 0));
    @(posedge HCLK); #1 HRESETn = 1'b0;
    clear_logs();
    @(negedge HCLK);
    chk("t5 pre-reset grant", 64'(grant_o), 64'd1);
    @(negedge HCLK);
    chk("t5 grant after rst", 64'(grant_o), 64'd0);
    chk("t5 s_cyc after rst", 64'(s_cyc_o), 64'd0);
    chk("t5 ack after rst", 64'(m_ack_o), 64'd0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    wait_idle("t5");
    chk("t5 first after rst", 64'(glog_idx[0]), 64'd0);

`ifdef MPSOC_WB_SPRAM_ARB_TIMEOUT_EN
    // Stalled RAM: forced error, then release once m0 drops cyc.
    a0 = acks[0];
    begin
      int e0 = errs[0];
      ram_stall = 1'b1;
      txq[0].push_back(mk(1, 8'h70, 32'h7777_7777, 1, 0));
      wait_idle("t6");
      chk("t6 errs", 64'(errs[0] - e0), 64'd1);
      chk("t6 acks", 64'(acks[0] - a0), 64'd0);
      ram_stall = 1'b0;
    end
`endif

    repeat (2) @(posedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
